// File: rtl/wave_seq_ctrl_pkg.sv
// Shared types and constants for the segment sequencer and its table.
package wave_seq_ctrl_pkg;

  localparam int unsigned ND_DAC1    = 12;
  localparam int unsigned NSEG_DEF   = 8;
  localparam int unsigned TW_DEF     = 24;
  localparam int unsigned RW_DEF     = 8;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned SW         = 2;

  typedef enum logic [1:0] {
    WSEL_SIN = 2'd0,
    WSEL_STW = 2'd1,
    WSEL_TRI = 2'd2,
    WSEL_SQU = 2'd3
  } wsel_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/wave_seq_ctrl_seg_table.sv
// Segment table: NSEG entries, synchronous write, asynchronous read.
module wave_seq_ctrl_seg_table #(
  parameter int unsigned NSEG = 8,
  parameter int unsigned EW   = 28,
  parameter int unsigned AW   = $clog2(NSEG)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [EW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [EW-1:0] o_rdata_c
);

  logic [EW-1:0] r_mem [NSEG];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/wave_seq_ctrl.sv
// Segment sequencer: walks the programmed table, drives Scal_DC and streams
// the selected scaled waveform to DAC1 over a valid/ready handshake.
module wave_seq_ctrl
  import wave_seq_ctrl_pkg::*;
#(
  parameter int unsigned DW   = ND_DAC1,
  parameter int unsigned NSEG = NSEG_DEF,
  parameter int unsigned TW   = TW_DEF,
  parameter int unsigned RW   = RW_DEF,
  parameter int unsigned AW   = $clog2(NSEG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [1:0]    cfg_wsel,
  input  logic          cfg_scal,
  input  logic [TW-1:0] cfg_dur,
  input  logic          cfg_last,
  output logic          cfg_err,
  input  logic          start,
  input  logic          stop,
  input  logic [RW-1:0] loop_cnt,
  input  logic          sample_tick,
  input  logic [DW-1:0] Sin_Scal_out,
  input  logic [DW-1:0] Stw_Scal_out,
  input  logic [DW-1:0] Tri_Scal_out,
  input  logic [DW-1:0] Squ_Scal_out,
  output logic          Scal_DC,
  output logic [DW-1:0] dac_data,
  output logic          dac_valid,
  input  logic          dac_ready,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [AW-1:0] seg_idx
);

  localparam int unsigned EW = TW + 4;
  localparam logic [DW-1:0] HALF = {1'b1, {(DW-1){1'b0}}};

  state_e        r_state, w_state_n;
  logic [AW-1:0] r_idx, w_idx_n;
  wsel_e         r_wsel, w_wsel_n;
  logic [TW-1:0] r_dur_cnt, w_dur_n;
  logic          r_last, w_last_n;
  logic [SW-1:0] r_settle, w_settle_n;
  logic [RW-1:0] r_loops, w_loops_n;
  logic          r_scal_dc, w_scal_n;
  logic [DW-1:0] r_dac_data, w_data_n;
  logic          r_dac_valid, w_valid_n;
  logic          r_overrun, w_overrun_n;
  logic          r_stopping, w_stopping_n;
  logic          r_busy, w_busy_n;
  logic          r_done, w_done_n;
  logic          r_cfg_err, w_cfg_err_n;

  logic          w_tbl_we;
  logic [EW-1:0] w_ent;
  logic [TW-1:0] w_ent_dur;
  logic          w_ent_scal;
  logic          w_ent_last;
  wsel_e         w_ent_wsel;
  logic [DW-1:0] w_mux;
  logic          w_last_seg;

  wave_seq_ctrl_seg_table #(
    .NSEG (NSEG),
    .EW   (EW),
    .AW   (AW)
  ) u_seg_table (
    .clk       (clk),
    .i_we      (w_tbl_we),
    .i_waddr   (cfg_addr),
    .i_wdata   ({cfg_wsel, cfg_scal, cfg_dur, cfg_last}),
    .i_raddr   (r_idx),
    .o_rdata_c (w_ent)
  );

  assign w_ent_last = w_ent[0];
  assign w_ent_dur  = w_ent[TW:1];
  assign w_ent_scal = w_ent[TW+1];
  assign w_ent_wsel = wsel_e'(w_ent[TW+3:TW+2]);
  assign w_tbl_we   = cfg_we && (r_state == ST_IDLE);
  assign w_last_seg = r_last || (r_idx == AW'(NSEG-1));

  // Waveform select for the current segment
  always_comb begin
    w_mux = Sin_Scal_out;
    case (r_wsel)
      WSEL_SIN: w_mux = Sin_Scal_out;
      WSEL_STW: w_mux = Stw_Scal_out;
      WSEL_TRI: w_mux = Tri_Scal_out;
      WSEL_SQU: w_mux = Squ_Scal_out;
      default:  w_mux = Sin_Scal_out;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_wsel_n     = r_wsel;
    w_dur_n      = r_dur_cnt;
    w_last_n     = r_last;
    w_settle_n   = r_settle;
    w_loops_n    = r_loops;
    w_scal_n     = r_scal_dc;
    w_data_n     = r_dac_data;
    w_valid_n    = r_dac_valid;
    w_overrun_n  = r_overrun;
    w_stopping_n = r_stopping;
    w_cfg_err_n  = cfg_we && (r_state != ST_IDLE);

    if (r_dac_valid && dac_ready) w_valid_n = 1'b0;

    if (stop && (r_state != ST_IDLE)) begin
      // Abort: let any pending sample complete, then return to IDLE silently
      w_state_n    = ST_DRAIN;
      w_stopping_n = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_loops_n    = loop_cnt;
            w_idx_n      = '0;
            w_overrun_n  = 1'b0;
            w_stopping_n = 1'b0;
            w_state_n    = ST_LOAD;
          end
        end
        ST_LOAD: begin
          w_wsel_n = w_ent_wsel;
          w_dur_n  = (w_ent_dur == '0) ? TW'(1) : w_ent_dur;
          w_last_n = w_ent_last;
          w_scal_n = w_ent_scal;
          if (w_ent_scal != r_scal_dc) begin
            w_settle_n = SW'(SETTLE_CYC);
            w_state_n  = ST_SETTLE;
          end else begin
            w_state_n  = ST_RUN;
          end
        end
        ST_SETTLE: begin
          if (r_settle <= SW'(1)) w_state_n = ST_RUN;
          else                    w_settle_n = r_settle - SW'(1);
        end
        ST_RUN: begin
          if (sample_tick) begin
            if (r_dac_valid && !dac_ready) begin
              w_overrun_n = 1'b1;
            end else begin
              w_data_n  = w_mux;
              w_valid_n = 1'b1;
              w_dur_n   = r_dur_cnt - TW'(1);
              if (r_dur_cnt == TW'(1)) begin
                if (!w_last_seg) begin
                  w_idx_n   = r_idx + AW'(1);
                  w_state_n = ST_LOAD;
                end else if ((r_loops == '0) || (r_loops > RW'(1))) begin
                  if (r_loops != '0) w_loops_n = r_loops - RW'(1);
                  w_idx_n   = '0;
                  w_state_n = ST_LOAD;
                end else begin
                  w_state_n = ST_DRAIN;
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          if (!r_dac_valid || dac_ready) begin
            w_data_n     = HALF;
            w_stopping_n = 1'b0;
            w_state_n    = r_stopping ? ST_IDLE : ST_DONE;
          end
        end
        ST_DONE: w_state_n = ST_IDLE;
        default: w_state_n = ST_IDLE;
      endcase
    end

    w_busy_n = (w_state_n != ST_IDLE);
    w_done_n = (w_state_n == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_wsel      <= WSEL_SIN;
      r_dur_cnt   <= '0;
      r_last      <= 1'b0;
      r_settle    <= '0;
      r_loops     <= '0;
      r_scal_dc   <= 1'b0;
      r_dac_data  <= HALF;
      r_dac_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_stopping  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_idx       <= w_idx_n;
      r_wsel      <= w_wsel_n;
      r_dur_cnt   <= w_dur_n;
      r_last      <= w_last_n;
      r_settle    <= w_settle_n;
      r_loops     <= w_loops_n;
      r_scal_dc   <= w_scal_n;
      r_dac_data  <= w_data_n;
      r_dac_valid <= w_valid_n;
      r_overrun   <= w_overrun_n;
      r_stopping  <= w_stopping_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
      r_cfg_err   <= w_cfg_err_n;
    end
  end

  assign Scal_DC   = r_scal_dc;
  assign dac_data  = r_dac_data;
  assign dac_valid = r_dac_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overrun   = r_overrun;
  assign cfg_err   = r_cfg_err;
  assign seg_idx   = r_idx;

endmodule
